// File: rtl/vga_fb_write_arbiter_if.sv
// Signal bundle for the framebuffer write arbiter: CPU pixel writes, fill
// commands/status and the registered framebuffer write port.
interface vga_fb_write_arbiter_if #(
    parameter int ADDR_W = 19
);
    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [7:0]        cpu_wr_data;
    logic              fill_start;
    logic [11:0]       fill_x0;
    logic [11:0]       fill_y0;
    logic [11:0]       fill_w;
    logic [11:0]       fill_h;
    logic [7:0]        fill_color;
    logic              fill_busy;
    logic              fill_done;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
        input  cpu_wr_ready, fill_busy, fill_done, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
        output cpu_wr_ready, fill_busy, fill_done, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/vga_fb_write_arbiter.sv
// Single framebuffer write port shared round-robin between a small CPU write
// FIFO and a clipped rectangle-fill engine.
module vga_fb_write_arbiter #(
    parameter int HSIZE      = 800,
    parameter int VSIZE      = 600,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_25M,
    input  logic                  rst,
    vga_fb_write_arbiter_if.slave bus
);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam logic [11:0]     HSIZE_C = 12'(HSIZE);
    localparam logic [11:0]     VSIZE_C = 12'(VSIZE);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count_q, count_d;
    logic              ready_q, push, cpu_req, fill_req, gnt_cpu, gnt_fill, prio_cpu;

    logic [11:0]       x0_q, y0_q, w_q, h_q;
    logic [11:0]       ew_q, ew_d, eh_q, eh_d, col_q, col_d, row_q, row_d;
    logic [7:0]        color_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [7:0]        fb_data_q;

    assign push     = bus.cpu_wr_valid && ready_q;
    assign cpu_req  = (count_q != '0);
    assign fill_req = (state_q == FILL);
    // prio_cpu is set whenever the fill engine was the last one granted
    assign gnt_cpu  = cpu_req && (prio_cpu || !fill_req);
    assign gnt_fill = fill_req && !gnt_cpu;

    always_comb begin
        count_d = count_q;
        if (push && !gnt_cpu)
            count_d = count_q + (PW+1)'(1);
        else if (!push && gnt_cpu)
            count_d = count_q - (PW+1)'(1);
    end

    always_comb begin
        state_d = state_q;
        ew_d    = ew_q;
        eh_d    = eh_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: if (bus.fill_start) state_d = SETUP;
            SETUP: begin
                if (w_q == '0 || h_q == '0 || x0_q >= HSIZE_C || y0_q >= VSIZE_C) begin
                    state_d = DONE;
                end else begin
                    ew_d    = (w_q < HSIZE_C - x0_q) ? w_q : HSIZE_C - x0_q;
                    eh_d    = (h_q < VSIZE_C - y0_q) ? h_q : VSIZE_C - y0_q;
                    base_d  = ADDR_W'(y0_q) * ADDR_W'(HSIZE) + ADDR_W'(x0_q);
                    col_d   = '0;
                    row_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (gnt_fill) begin
                    if (col_q == ew_q - 12'd1) begin
                        col_d  = '0;
                        row_d  = row_q + 12'd1;
                        base_d = base_q + ADDR_W'(HSIZE);
                        if (row_q == eh_q - 12'd1) state_d = DONE;
                    end else begin
                        col_d = col_q + 12'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25M) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.cpu_wr_addr;
            fifo_data[wr_ptr] <= bus.cpu_wr_data;
        end
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != DEPTH_C);
            if (push)    wr_ptr <= wr_ptr + PW'(1);
            if (gnt_cpu) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            ew_q    <= '0;
            eh_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            ew_q    <= ew_d;
            eh_q    <= eh_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            if (state_q == IDLE && bus.fill_start) begin
                x0_q    <= bus.fill_x0;
                y0_q    <= bus.fill_y0;
                w_q     <= bus.fill_w;
                h_q     <= bus.fill_h;
                color_q <= bus.fill_color;
            end
        end
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            prio_cpu  <= 1'b1;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            fb_we_q <= gnt_cpu || gnt_fill;
            if (gnt_cpu) begin
                prio_cpu  <= 1'b0;
                fb_addr_q <= fifo_addr[rd_ptr];
                fb_data_q <= fifo_data[rd_ptr];
            end else if (gnt_fill) begin
                prio_cpu  <= 1'b1;
                fb_addr_q <= base_q + ADDR_W'(col_q);
                fb_data_q <= color_q;
            end
        end
    end

    assign bus.cpu_wr_ready = ready_q;
    assign bus.fill_busy    = (state_q == SETUP) || (state_q == FILL);
    assign bus.fill_done    = (state_q == DONE);
    assign bus.fb_we        = fb_we_q;
    assign bus.fb_addr      = fb_addr_q;
    assign bus.fb_data      = fb_data_q;
endmodule
